// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit
// positions, bus request bundle and the serial FSM state encoding.
package uart_pkg;

  localparam logic [1:0] UART_TXDATA  = 2'd0;
  localparam logic [1:0] UART_RXDATA  = 2'd1;
  localparam logic [1:0] UART_STATUS  = 2'd2;
  localparam logic [1:0] UART_BAUDDIV = 2'd3;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_TX_BUSY    = 2;
  localparam int ST_RX_VALID   = 3;
  localparam int ST_RX_OVERRUN = 4;
  localparam int ST_FRAME_ERR  = 5;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [1:0] reg_sel;
  } uart_req_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. A push while full is dropped even
// if a pop happens on the same edge.
module uart_tx_fifo #(
  parameter  int TX_DEPTH = 4,
  localparam int AW       = $clog2(TX_DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  logic [TX_DEPTH-1:0][7:0] mem;
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic                     push_ok, pop_ok;

  assign full    = (count == (AW+1)'(TX_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= din;

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART on the data-memory bus: TX FIFO plus shifter, RX
// holding register, combinational reads with side effects at the clock edge.
module uart_mmio
  import uart_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV_RST = 16'd867,
  parameter int          TX_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [1:0]  we,
  input  logic        rd_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  input  logic        rx
);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  uart_req_t req;
  assign req = '{wr: sel & (we != 2'b00), rd: sel & rd_en, reg_sel: addr[3:2]};

  logic [15:0] baud_div;
  always_ff @(posedge clk)
    if (reset) baud_div <= BAUD_DIV_RST;
    else if (req.wr && req.reg_sel == UART_BAUDDIV) baud_div <= wdata[15:0];

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  assign fifo_push = req.wr && req.reg_sel == UART_TXDATA;

  uart_tx_fifo #(.TX_DEPTH(TX_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(fifo_push), .pop(fifo_pop), .din(wdata[7:0]),
    .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
  );

  // ---------------- transmitter ----------------
  uart_state_e tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= S_IDLE; tx_cnt <= '0; tx_div <= '0; tx_bit <= '0; tx_shift <= '0;
    end else begin
      tx_state <= tx_state_n; tx_cnt <= tx_cnt_n; tx_div <= tx_div_n;
      tx_bit <= tx_bit_n; tx_shift <= tx_shift_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state; tx_cnt_n = tx_cnt; tx_div_n = tx_div;
    tx_bit_n = tx_bit; tx_shift_n = tx_shift; fifo_pop = 1'b0;
    if (tx_state == S_IDLE) begin
      if (!fifo_empty) begin
        fifo_pop = 1'b1; tx_shift_n = fifo_dout; tx_div_n = baud_div;
        tx_cnt_n = baud_div; tx_state_n = S_START;
      end
    end else if (tx_cnt != 16'd0) begin
      tx_cnt_n = tx_cnt - 16'd1;
    end else begin
      tx_cnt_n = tx_div;
      case (tx_state)
        S_START: begin tx_bit_n = '0; tx_state_n = S_DATA; end
        S_DATA: begin
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_bit_n   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_n = S_STOP;
        end
        S_STOP: begin
          // back-to-back frames: reload straight into START, no idle bit
          if (!fifo_empty) begin
            fifo_pop = 1'b1; tx_shift_n = fifo_dout; tx_div_n = baud_div;
            tx_cnt_n = baud_div; tx_state_n = S_START;
          end else tx_state_n = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign tx_busy = (tx_state != S_IDLE);
  assign tx = (tx_state == S_START) ? 1'b0 : (tx_state == S_DATA) ? tx_shift[0] : 1'b1;

  // ---------------- receiver ----------------
  logic [1:0]  rx_sync;
  logic        rx_s;
  uart_state_e rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n, rx_half;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n, rx_byte;
  logic        rx_brk, rx_brk_n, rx_done, rx_ferr;
  logic        rx_valid, rx_overrun, frame_err, rd_rx, rd_st;

  assign rx_s    = rx_sync[1];
  assign rx_half = 16'(({1'b0, baud_div} + 17'd1) >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync <= 2'b11; rx_state <= S_IDLE; rx_cnt <= '0; rx_div <= '0;
      rx_bit <= '0; rx_shift <= '0; rx_brk <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx}; rx_state <= rx_state_n; rx_cnt <= rx_cnt_n;
      rx_div <= rx_div_n; rx_bit <= rx_bit_n; rx_shift <= rx_shift_n; rx_brk <= rx_brk_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state; rx_cnt_n = rx_cnt; rx_div_n = rx_div; rx_bit_n = rx_bit;
    rx_shift_n = rx_shift; rx_brk_n = rx_brk; rx_done = 1'b0; rx_ferr = 1'b0;
    case (rx_state)
      S_IDLE:
        if (!rx_s) begin rx_div_n = baud_div; rx_cnt_n = rx_half; rx_state_n = S_START; end
      S_START:
        if (rx_cnt > 16'd1) rx_cnt_n = rx_cnt - 16'd1;
        else if (rx_s) rx_state_n = S_IDLE;
        else begin rx_cnt_n = rx_div; rx_bit_n = '0; rx_state_n = S_DATA; end
      S_DATA:
        if (rx_cnt != 16'd0) rx_cnt_n = rx_cnt - 16'd1;
        else begin
          rx_cnt_n   = rx_div;
          rx_shift_n = {rx_s, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_n = S_STOP;
        end
      S_STOP:
        // after a bad stop bit, hold here until the line is released
        if (rx_brk) begin
          if (rx_s) begin rx_brk_n = 1'b0; rx_state_n = S_IDLE; end
        end else if (rx_cnt != 16'd0) rx_cnt_n = rx_cnt - 16'd1;
        else if (rx_s) begin rx_done = 1'b1; rx_state_n = S_IDLE; end
        else begin rx_ferr = 1'b1; rx_brk_n = 1'b1; end
      default: ;
    endcase
  end

  assign rd_rx = req.rd && req.reg_sel == UART_RXDATA;
  assign rd_st = req.rd && req.reg_sel == UART_STATUS;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid <= 1'b0; rx_overrun <= 1'b0; frame_err <= 1'b0; rx_byte <= '0;
    end else begin
      if (rx_done) rx_byte <= rx_shift;
      rx_valid   <= rx_done | (rx_valid & ~rd_rx);
      rx_overrun <= (rx_overrun & ~rd_st) | (rx_done & rx_valid & ~rd_rx);
      frame_err  <= (frame_err & ~rd_st) | rx_ferr;
    end
  end

  // ---------------- read mux ----------------
  logic [31:0] status;
  always_comb begin
    status = '0;
    status[ST_TX_FULL]    = fifo_full;
    status[ST_TX_EMPTY]   = fifo_empty;
    status[ST_TX_BUSY]    = tx_busy;
    status[ST_RX_VALID]   = rx_valid;
    status[ST_RX_OVERRUN] = rx_overrun;
    status[ST_FRAME_ERR]  = frame_err;
  end

  always_comb begin
    rdata = '0;
    if (sel)
      case (req.reg_sel)
        UART_RXDATA:  rdata = {23'b0, rx_valid, rx_byte};
        UART_STATUS:  rdata = status;
        UART_BAUDDIV: rdata = {16'b0, baud_div};
        default:      rdata = '0;
      endcase
  end

  logic unused_ok;
  assign unused_ok = ^{addr[1:0], wdata[31:16], fifo_count};

endmodule

// File: tb/tb_uart_mmio.sv
// Randomized bench for uart_mmio: TX line decoded against expected frames,
// RX flags tracked by a small event-level model.
module tb_uart_mmio;
  import uart_pkg::*;

  localparam logic [15:0] DIV_RST = 16'd867;
  localparam int          DEPTH   = 4;

  logic        clk = 1'b0, reset = 1'b1, sel = 1'b0, rd_en = 1'b0;
  logic        loop_en = 1'b0, rx_drv = 1'b1, mon_en = 1'b0;
  logic [3:0]  addr = '0;
  logic [1:0]  we = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx, rx_line;

  int n_chk = 0, n_fail = 0;
  logic       mon_q[$];
  logic [7:0] exp_tx_q[$];
  logic       m_valid, m_ovr, m_ferr;
  logic [7:0] m_byte;

  always #5 clk = ~clk;
  assign rx_line = loop_en ? tx : rx_drv;
  always @(negedge clk) if (mon_en) mon_q.push_back(tx);

  uart_mmio #(.BAUD_DIV_RST(DIV_RST), .TX_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .sel(sel), .addr(addr), .we(we), .rd_en(rd_en),
    .wdata(wdata), .rdata(rdata), .tx(tx), .rx(rx_line)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; addr = {a, 2'($urandom)}; we = 2'($urandom_range(1, 3)); wdata = d;
    @(posedge clk); #1 sel = 1'b0; we = 2'b00;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; rd_en = 1'b1; addr = {a, 2'($urandom)};
    #1 d = rdata;
    @(posedge clk); #1 sel = 1'b0; rd_en = 1'b0;
  endtask

  // side-effect-free look, taken between edges
  task automatic peek(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; addr = {a, 2'($urandom)};
    #1 d = rdata;
    sel = 1'b0;
  endtask

  function automatic logic [31:0] exp_status();
    return {26'b0, m_ferr, m_ovr, m_valid, 1'b0, 1'b1, 1'b0};
  endfunction

  function automatic logic [31:0] exp_rxdata();
    return {23'b0, m_valid, m_byte};
  endfunction

  function automatic logic frame_bit(input logic [7:0] b, input int n);
    if (n == 0) return 1'b0;
    if (n == 9) return 1'b1;
    return b[n-1];
  endfunction

  task automatic m_frame(input logic [7:0] b);
    if (m_valid) m_ovr = 1'b1;
    m_valid = 1'b1;
    m_byte  = b;
  endtask

  task automatic chk_regs(input string tag);
    logic [31:0] d;
    @(negedge clk);
    peek(UART_STATUS, d); chk({tag, "_status"}, d, exp_status());
    peek(UART_RXDATA, d); chk({tag, "_rxdata"}, d, exp_rxdata());
  endtask

  // 4 clocks per bit, matching BAUDDIV=3
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rx_drv = fr[i];
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic tx_decode(input string tag, input int nfr);
    int i;
    logic [39:0] got, exp;
    logic [7:0]  idle;
    i = 0;
    while (i < mon_q.size() && mon_q[i] !== 1'b0) i++;
    for (int f = 0; f < nfr; f++) begin
      for (int k = 0; k < 40; k++) begin
        exp[k] = frame_bit(exp_tx_q[f], k / 4);
        got[k] = (i + k < mon_q.size()) ? mon_q[i+k] : 1'bx;
      end
      chk(tag, {24'b0, got}, {24'b0, exp});
      i += 40;
    end
    for (int k = 0; k < 8; k++) idle[k] = (i + k < mon_q.size()) ? mon_q[i+k] : 1'b0;
    chk({tag, "_idle"}, idle, 8'hFF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, r;
    logic [7:0]  b;
    logic [7:0]  q[$];
    int          busy_cnt, pre, lows;
    logic        eng_idle;
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_byte = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    rd(UART_TXDATA, d);  chk("rst_txdata", d, 32'h0);
    rd(UART_RXDATA, d);  chk("rst_rxdata", d, 32'h0);
    rd(UART_STATUS, d);  chk("rst_status", d, 32'h2);
    rd(UART_BAUDDIV, d); chk("rst_bauddiv", d, {16'b0, DIV_RST});
    chk("rst_tx", tx, 1'b1);
    @(negedge clk); addr = {UART_BAUDDIV, 2'b00};
    #1 chk("rdata_nosel", rdata, 32'h0);

    d = $urandom;
    wr(UART_BAUDDIV, d); rd(UART_BAUDDIV, r); chk("baud_rb", r, {16'b0, d[15:0]});
    wr(UART_BAUDDIV, 32'h3);

    // single frames: line shape and busy duration
    for (int t = 0; t < 2; t++) begin
      b = (t == 0) ? 8'hA5 : 8'($urandom);
      exp_tx_q.delete(); exp_tx_q.push_back(b); mon_q.delete(); busy_cnt = 0;
      wr(UART_TXDATA, {24'($urandom), b});
      for (int k = 0; k < 60; k++) begin
        @(negedge clk); mon_q.push_back(tx);
        peek(UART_STATUS, d); busy_cnt += int'(d[2]);
      end
      tx_decode("tx_single", 1);
      chk("tx_busy_clks", busy_cnt, 40);
      chk("tx_idle_status", d, 32'h2);
    end

    // back-to-back burst overflowing the FIFO
    q.delete(); exp_tx_q.delete(); mon_q.delete(); eng_idle = 1'b1; mon_en = 1'b1;
    for (int j = 0; j < 6; j++) begin
      b   = 8'($urandom);
      pre = q.size();
      if (eng_idle && pre > 0) begin exp_tx_q.push_back(q.pop_front()); eng_idle = 1'b0; end
      if (pre < DEPTH) q.push_back(b);
      wr(UART_TXDATA, {24'b0, b});
    end
    @(negedge clk); peek(UART_STATUS, d);
    chk("tx_full", d[0], q.size() == DEPTH);
    while (q.size() > 0) exp_tx_q.push_back(q.pop_front());
    repeat (220) @(negedge clk);
    mon_en = 1'b0;
    tx_decode("tx_burst", exp_tx_q.size());

    // loopback: valid, read-clear, overrun
    loop_en = 1'b1;
    for (int t = 0; t < 3; t++) begin
      b = (t == 0) ? 8'h3C : 8'($urandom);
      wr(UART_TXDATA, {24'b0, b});
      repeat (50) @(negedge clk);
      m_frame(b);
      peek(UART_RXDATA, d); chk("loop_rxdata", d, exp_rxdata());
      if (t == 0) begin
        rd(UART_RXDATA, d); chk("loop_rd", d, exp_rxdata());
        m_valid = 1'b0;
        chk_regs("loop_rd_clr");
      end
    end
    rd(UART_STATUS, d); chk("loop_status_rd", d, exp_status());
    m_ovr = 1'b0; m_ferr = 1'b0;
    chk_regs("loop_st_clr");
    loop_en = 1'b0;

    // driven RX: good frame, bad stop bit, glitch
    b = 8'($urandom); send_rx(b, 1'b1); repeat (8) @(negedge clk);
    m_frame(b); chk_regs("rx_good");
    rd(UART_STATUS, d); chk("rx_status_rd", d, exp_status());
    m_ovr = 1'b0; m_ferr = 1'b0;
    send_rx(8'($urandom), 1'b0); repeat (12) @(negedge clk);
    rx_drv = 1'b1; repeat (10) @(negedge clk);
    m_ferr = 1'b1; chk_regs("rx_ferr");
    @(negedge clk); rx_drv = 1'b0; @(negedge clk); rx_drv = 1'b1;
    repeat (10) @(negedge clk);
    chk_regs("rx_glitch");
    rd(UART_STATUS, d); chk("rx_ferr_rd", d, exp_status());
    m_ovr = 1'b0; m_ferr = 1'b0;
    rd(UART_RXDATA, d); chk("rx_byte_rd", d, exp_rxdata());
    m_valid = 1'b0;
    b = 8'($urandom); send_rx(b, 1'b1); repeat (8) @(negedge clk);
    m_frame(b); chk_regs("rx_after_glitch");

    // reset in the middle of both frames
    loop_en = 1'b1;
    wr(UART_TXDATA, {24'b0, 8'($urandom)});
    repeat (20) @(negedge clk);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_byte = '0;
    chk("rst2_tx", tx, 1'b1);
    peek(UART_BAUDDIV, d); chk("rst2_bauddiv", d, {16'b0, DIV_RST});
    chk_regs("rst2");
    lows = 0;
    for (int k = 0; k < 50; k++) begin @(negedge clk); lows += int'(!tx); end
    chk("rst2_tx_quiet", lows, 0);
    chk_regs("rst2_late");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
